ysyx_22040127_rr_arb_mux: RTL and testbench

Parametrised N-channel round-robin arbiter/multiplexer with valid/ready handshakes and a registered output stage, optionally burst-locked. It generalises the key-select mux from a static selector into a sequential one. Requestors present flattened data; the block picks a winner fairly and forwards one beat per cycle downstream. It sits between the IFU/LSU request ports and the shared memory/AXI bridge.

---
 rtl/ysyx_22040127_arb_pkg.sv | 17 +
 rtl/ysyx_22040127_rr_pick.sv | 52 +++++
 rtl/ysyx_22040127_rr_arb_mux.sv | 140 ++++++++++++++
 tb/tb_ysyx_22040127_rr_arb_mux.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040127_arb_pkg.sv
// Shared definitions for the round-robin arbiter/multiplexer.
//   arb_state_e : arbitration state (free round-robin or burst-locked)
//   clog2_min1  : channel-index width, never narrower than one bit
package ysyx_22040127_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ysyx_22040127_rr_pick.sv
// Combinational pointer-rotated priority search.
// Ports:
//   req        : per-channel request
//   mask       : channels allowed while mask_en is high
//   mask_en    : restrict the search to mask (burst lock)
//   ptr        : highest-priority channel; search wraps NR_CH-1 -> 0
//   gnt_onehot : one-hot winner (all zero when nothing eligible)
//   gnt_idx    : binary winner index (0 when nothing eligible)
//   any        : at least one eligible request
module ysyx_22040127_rr_pick #(
  parameter int NR_CH   = 4,
  parameter int IDX_LEN = 2
) (
  input  logic [NR_CH-1:0]   req,
  input  logic [NR_CH-1:0]   mask,
  input  logic               mask_en,
  input  logic [IDX_LEN-1:0] ptr,
  output logic [NR_CH-1:0]   gnt_onehot,
  output logic [IDX_LEN-1:0] gnt_idx,
  output logic               any
);

  logic [NR_CH-1:0] elig;

  assign elig = mask_en ? (req & mask) : req;

  // The winner is the eligible channel with the smallest forward distance
  // from ptr, which is the same as scanning ptr, ptr+1, ... with wrap.
  always_comb begin : search
    int best;
    int best_d;
    int d;
    best   = 0;
    best_d = NR_CH;
    d      = 0;
    for (int i = 0; i < NR_CH; i++) begin
      d = i - int'(ptr);
      if (d < 0) d = d + NR_CH;
      if (elig[i] && (d < best_d)) begin
        best   = i;
        best_d = d;
      end
    end
    any        = (best_d < NR_CH);
    gnt_idx    = IDX_LEN'(best);
    gnt_onehot = '0;
    for (int i = 0; i < NR_CH; i++) begin
      gnt_onehot[i] = any && (i == best);
    end
  end

endmodule

// File: rtl/ysyx_22040127_rr_arb_mux.sv
// N-channel round-robin arbiter/multiplexer with a registered output slot.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : per-channel request handshake (in_ready one-hot)
//   in_last             : end of burst, only meaningful with LOCK_EN=1
//   in_data             : channel n at [DATA_LEN*(n+1)-1 : DATA_LEN*n]
//   out_valid/out_ready : downstream handshake
//   out_data/out_id     : forwarded payload and its source channel
//   out_last            : forwarded in_last, constant 1 with LOCK_EN=0
//
// state | meaning
// ARB   | round-robin search from ptr over all valid channels
// LOCK  | mid-burst; only lock_ch may be granted until its last beat
module ysyx_22040127_rr_arb_mux
  import ysyx_22040127_arb_pkg::*;
#(
  parameter  int NR_CH    = 4,
  parameter  int DATA_LEN = 64,
  parameter  bit LOCK_EN  = 1'b0,
  localparam int IDX_LEN  = clog2_min1(NR_CH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NR_CH-1:0]          in_valid,
  output logic [NR_CH-1:0]          in_ready,
  input  logic [NR_CH-1:0]          in_last,
  input  logic [NR_CH*DATA_LEN-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_LEN-1:0]       out_data,
  output logic [IDX_LEN-1:0]        out_id,
  output logic                      out_last
);

  arb_state_e           state_q, state_d;
  logic [IDX_LEN-1:0]   ptr_q, ptr_d;
  logic [IDX_LEN-1:0]   lock_q, lock_d;
  logic                 slot_free;
  logic                 accept;
  logic                 mask_en;
  logic [NR_CH-1:0]     lock_mask;
  logic [NR_CH-1:0]     gnt_onehot;
  logic [IDX_LEN-1:0]   gnt_idx;
  logic                 gnt_any;
  logic [DATA_LEN-1:0]  sel_data;
  logic                 sel_last;

  function automatic logic [IDX_LEN-1:0] wrap_inc(input logic [IDX_LEN-1:0] x);
    return (x == IDX_LEN'(NR_CH - 1)) ? '0 : x + IDX_LEN'(1);
  endfunction

  // The slot refills in the same cycle it drains, giving one beat per cycle.
  assign slot_free = !out_valid || out_ready;
  assign mask_en   = LOCK_EN && (state_q == LOCK);

  always_comb begin
    lock_mask = '0;
    for (int i = 0; i < NR_CH; i++) begin
      lock_mask[i] = (lock_q == IDX_LEN'(i));
    end
  end

  ysyx_22040127_rr_pick #(
    .NR_CH   (NR_CH),
    .IDX_LEN (IDX_LEN)
  ) u_pick (
    .req        (in_valid),
    .mask       (lock_mask),
    .mask_en    (mask_en),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // AND-OR select over the one-hot grant; no binary-index mux.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NR_CH; i++) begin
      sel_data = sel_data | (in_data[i*DATA_LEN +: DATA_LEN] & {DATA_LEN{gnt_onehot[i]}});
      sel_last = sel_last | (in_last[i] & gnt_onehot[i]);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

  // Next-state logic. In LOCK the picker can only return lock_q, so
  // gnt_idx doubles as lock_ch when the burst closes.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    if (accept) begin
      if (!LOCK_EN) begin
        ptr_d = wrap_inc(gnt_idx);
      end else if (sel_last) begin
        state_d = ARB;
        ptr_d   = wrap_inc(gnt_idx);
      end else begin
        state_d = LOCK;
        lock_d  = gnt_idx;
      end
    end
  end

  // Output logic
  always_comb begin
    in_ready = slot_free ? gnt_onehot : '0;
    accept   = slot_free && gnt_any;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_id    <= gnt_idx;
      out_last  <= LOCK_EN ? sel_last : 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_22040127_rr_arb_mux.sv
module tb_ysyx_22040127_rr_arb_mux;

  logic clk = 1'b0;
  logic rst_n;

  // Instance A: 4 channels, burst lock enabled
  logic [3:0]  a_valid, a_ready, a_last;
  logic [63:0] a_data;
  logic        a_ov, a_or, a_ol;
  logic [15:0] a_od;
  logic [1:0]  a_oid;

  // Instance B: 3 channels, no lock
  logic [2:0]  b_valid, b_ready, b_last;
  logic [47:0] b_data;
  logic        b_ov, b_or, b_ol;
  logic [15:0] b_od;
  logic [1:0]  b_oid;

  always #5 clk = ~clk;

  ysyx_22040127_rr_arb_mux #(.NR_CH(4), .DATA_LEN(16), .LOCK_EN(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_valid), .in_ready(a_ready), .in_last(a_last), .in_data(a_data),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_id(a_oid), .out_last(a_ol)
  );

  ysyx_22040127_rr_arb_mux #(.NR_CH(3), .DATA_LEN(16), .LOCK_EN(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_valid), .in_ready(b_ready), .in_last(b_last), .in_data(b_data),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_id(b_oid), .out_last(b_ol)
  );

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        last;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int    a_log[$];

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: arbitration pointer, burst lock, output slot
  int m_ptr[2];
  int m_lock_ch[2];
  bit m_locked[2];
  bit m_ov[2];

  logic [3:0] a_hs;
  logic [2:0] b_hs;
  int a_burst[4];
  int exp_burst[5] = '{0, 1, 1, 1, 2};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of the reference model, evaluated with inputs settled.
  task automatic model_step(input int k, input int nch, input bit lock_en,
                            input logic [3:0] v, input logic [3:0] l, input logic [63:0] d,
                            input logic [3:0] rdy, input logic ov, input logic ordy);
    int         w;
    bit         sf;
    logic [3:0] exp_rdy;
    beat_t      e;
    string      p;
    p = (k == 0) ? "a" : "b";
    check({p, "_out_valid"}, ov, m_ov[k]);
    sf = !m_ov[k] || ordy;
    w  = -1;
    for (int j = 0; j < nch; j++) begin
      int c = (m_ptr[k] + j) % nch;
      if (w < 0 && v[c] && (!m_locked[k] || c == m_lock_ch[k])) w = c;
    end
    exp_rdy = '0;
    if (sf && w >= 0) exp_rdy[w] = 1'b1;
    check({p, "_in_ready"}, rdy, exp_rdy);
    if (sf && w >= 0) begin
      e.id   = w;
      e.data = d[w*16 +: 16];
      e.last = lock_en ? l[w] : 1'b1;
      if (k == 0) qa.push_back(e); else qb.push_back(e);
      if (!lock_en || l[w]) begin
        m_ptr[k]    = (w + 1) % nch;
        m_locked[k] = 1'b0;
      end else begin
        m_locked[k]  = 1'b1;
        m_lock_ch[k] = w;
      end
      m_ov[k] = 1'b1;
    end else if (ordy) begin
      m_ov[k] = 1'b0;
    end
  endtask

  // Stimulus-side model: predicts accepts and pushes expected beats
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_ptr[k] = 0; m_lock_ch[k] = 0; m_locked[k] = 1'b0; m_ov[k] = 1'b0;
      end
      qa.delete();
      qb.delete();
      a_hs = '0;
      b_hs = '0;
    end else begin
      a_hs = a_valid & a_ready;
      b_hs = b_valid & b_ready;
      model_step(0, 4, 1'b1, a_valid, a_last, a_data, a_ready, a_ov, a_or);
      model_step(1, 3, 1'b0, {1'b0, b_valid}, {1'b0, b_last}, {16'h0, b_data},
                 {1'b0, b_ready}, b_ov, b_or);
    end
  end

  // Monitor: pops one expected beat per downstream handshake
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (a_ov && a_or) begin
        a_log.push_back(int'(a_oid));
        if (qa.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL a_beat: unexpected beat id %0d data 0x%0h, want none", a_oid, a_od);
        end else begin
          e = qa.pop_front();
          check("a_out_id", a_oid, e.id);
          check("a_out_data", a_od, e.data);
          check("a_out_last", a_ol, e.last);
        end
      end
      if (b_ov && b_or) begin
        if (qb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL b_beat: unexpected beat id %0d data 0x%0h, want none", b_oid, b_od);
        end else begin
          e = qb.pop_front();
          check("b_out_id", b_oid, e.id);
          check("b_out_data", b_od, e.data);
          check("b_out_last", b_ol, e.last);
        end
      end
    end
  end

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_a_out_valid", a_ov, 0);
    check("rst_b_out_valid", b_ov, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic do_reset();
    a_valid = '0; b_valid = '0;
    @(posedge clk);
    #3;
    pulse_reset();
  endtask

  task automatic drive_a_rand();
    for (int c = 0; c < 4; c++) begin
      if (a_hs[c]) begin
        a_valid[c] = 1'b0;
        if (a_burst[c] > 0) a_burst[c]--;
      end
      if (!a_valid[c]) begin
        if (a_burst[c] == 0 && $urandom_range(0, 2) == 0) a_burst[c] = $urandom_range(1, 4);
        if (a_burst[c] > 0 && $urandom_range(0, 3) != 0) begin
          a_valid[c] = 1'b1;
          a_data[c*16 +: 16] = 16'($urandom);
          a_last[c] = (a_burst[c] == 1);
        end
      end
    end
    a_or = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive_b_rand();
    for (int c = 0; c < 3; c++) begin
      if (b_hs[c]) b_valid[c] = 1'b0;
      if (!b_valid[c] && $urandom_range(0, 2) != 0) begin
        b_valid[c] = 1'b1;
        b_data[c*16 +: 16] = 16'($urandom);
        b_last[c] = 1'($urandom);
      end
    end
    b_or = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = '0; a_last = '0; a_data = '0; a_or = 1'b0;
    b_valid = '0; b_last = '0; b_data = '0; b_or = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Reset / idle
    @(negedge clk);
    check("idle_a_out_valid", a_ov, 0);
    check("idle_a_in_ready", a_ready, 4'b0000);
    check("idle_a_out_id", a_oid, 0);
    check("idle_a_out_data", a_od, 0);
    check("idle_a_out_last", a_ol, 0);
    check("idle_b_out_valid", b_ov, 0);
    check("idle_b_in_ready", b_ready, 3'b000);

    // Rotation: all four valid, single-beat requests
    @(posedge clk); #1;
    a_log.delete();
    a_valid = 4'hF; a_last = 4'hF;
    a_data  = 64'h00A3_00A2_00A1_00A0;
    a_or    = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("rot_beats", a_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("rot_id", (i < a_log.size()) ? a_log[i] : -1, i % 4);
    end

    // Backpressure with ch2 buffered
    @(posedge clk); #1;
    a_or = 1'b0;
    check("bp_id", a_oid, 2);
    check("bp_data", a_od, 16'h00A2);
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_data", a_od, 16'h00A2);
      check("bp_in_ready", a_ready, 4'b0000);
      check("bp_out_valid", a_ov, 1);
    end
    @(posedge clk); #1;
    a_or = 1'b1;
    @(posedge clk); #1;
    check("bp_next_id", a_oid, 3);
    check("bp_next_data", a_od, 16'h00A3);
    a_valid = '0;
    do_reset();

    // Burst lock: ch1 three beats while ch0 and ch2 wait
    @(posedge clk); #1;
    a_log.delete();
    a_valid = 4'b0001; a_last = 4'b1111; a_data = 64'h0000_0000_0000_00B0; a_or = 1'b1;
    @(posedge clk); #1;
    a_valid = 4'b0111; a_last = 4'b0101; a_data = 64'h0000_00B2_00C1_00B0;
    @(posedge clk); #1;
    a_valid[1] = 1'b0;
    @(negedge clk);
    check("lock_gap_in_ready", a_ready, 4'b0000);
    @(posedge clk); #1;
    a_valid[1] = 1'b1; a_data[31:16] = 16'h00C2; a_last[1] = 1'b0;
    @(posedge clk); #1;
    a_data[31:16] = 16'h00C3; a_last[1] = 1'b1;
    @(posedge clk); #1;
    a_valid[1] = 1'b0;
    @(posedge clk); #1;
    a_valid = '0;
    @(posedge clk); #1;
    check("lock_beats", a_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("lock_id", (i < a_log.size()) ? a_log[i] : -1, exp_burst[i]);
    end
    do_reset();

    // Async reset mid-burst with a buffered beat
    @(posedge clk); #1;
    a_valid = 4'b1000; a_last = 4'b0000; a_data = 64'h00D3_0000_0000_00D0; a_or = 1'b1;
    @(posedge clk); #1;
    a_valid = 4'b1001; a_last = 4'b0001; a_or = 1'b0;
    check("arst_pre_valid", a_ov, 1);
    check("arst_pre_id", a_oid, 3);
    @(negedge clk);
    check("arst_locked_ready", a_ready, 4'b0000);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", a_ov, 0);
    check("arst_in_ready", a_ready, 4'b0001);
    a_or = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_next_id", a_oid, 0);
    check("arst_next_data", a_od, 16'h00D0);
    check("arst_next_valid", a_ov, 1);
    a_valid = '0;
    do_reset();

    // Non-power-of-two wrap on the 3-channel instance
    @(posedge clk); #1;
    b_valid = 3'b100; b_data = 48'h00E2_0000_0000; b_last = 3'b000; b_or = 1'b1;
    @(posedge clk); #1;
    check("wrap_first_id", b_oid, 2);
    b_valid = 3'b101; b_data = 48'h00E2_0000_00E0;
    @(posedge clk); #1;
    check("wrap_id", b_oid, 0);
    check("wrap_data", b_od, 16'h00E0);
    check("wrap_last_forced", b_ol, 1);
    b_valid = '0;
    do_reset();

    // Randomised traffic on both instances
    for (int c = 0; c < 4; c++) a_burst[c] = 0;
    a_valid = '0; b_valid = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      drive_a_rand();
      drive_b_rand();
      if (cyc == 1500) begin
        #2;
        pulse_reset();
      end
    end

    // Drain, bounded
    @(posedge clk); #1;
    a_valid = '0; b_valid = '0; a_or = 1'b1; b_or = 1'b1;
    for (int n = 0; n < 20 && (qa.size() != 0 || qb.size() != 0 || a_ov || b_ov); n++) begin
      @(posedge clk); #1;
    end
    check("drain_qa", qa.size(), 0);
    check("drain_qb", qb.size(), 0);
    check("drain_a_out_valid", a_ov, 0);
    check("drain_b_out_valid", b_ov, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
